// File: rtl/fetch_seq8_pkg.sv
// Shared types and opcode constants for the fetch_seq8 instruction sequencer.
package fetch_seq8_pkg;

  typedef logic [7:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    ISSUE,
    ISSUE2,
    HALTED
  } state_e;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_SKIP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  function automatic logic [1:0] opcode(input word_t w);
    return w[7:6];
  endfunction

endpackage

// File: rtl/fetch_seq8_if.sv
// ROM request/ack bus plus the instruction handoff to the consumer.
interface fetch_seq8_if;
  import fetch_seq8_pkg::*;

  logic  mem_req;
  word_t mem_addr;
  logic  mem_ack;
  word_t mem_rdata;
  logic  instr_valid;
  word_t instr;
  logic  instr_ready;

  modport master (
    output mem_req, mem_addr, instr_valid, instr,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_seq8_dec.sv
// Combinational opcode decoder: classifies instr[7:6] and forms the jump target.
module fetch_seq8_dec
  import fetch_seq8_pkg::*;
(
  input  word_t instr,
  output logic  is_jmp,
  output logic  is_skip,
  output logic  is_halt,
  output word_t jmp_tgt
);
  always_comb begin
    is_jmp  = (opcode(instr) == OP_JMP);
    is_skip = (opcode(instr) == OP_SKIP);
    is_halt = (opcode(instr) == OP_HALT);
    jmp_tgt = {2'b00, instr[5:0]};
  end
endmodule

// File: rtl/fetch_seq8.sv
// fetch_seq8: fetch/issue sequencer driving prog_counter8 strobes and an instruction ROM.
// Define FETCH_SEQ8_TIMEOUT_EN to fault (err + halted) when mem_ack never arrives.
module fetch_seq8
  import fetch_seq8_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  run,
  input  word_t pc_q,
  output logic  pc_en,
  output logic  pc_load,
  output word_t pc_load_val,
  output logic  pc_oe,
  output logic  halted,
  output logic  err,
  fetch_seq8_if.master bus
);
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_ack_timeout
    $error("fetch_seq8: ACK_TIMEOUT must be in 1..255");
  end

  state_e state_q, state_d;
  logic   mem_req_q, mem_req_d, pc_oe_q, pc_oe_d;
  logic   pc_en_q, pc_en_d, pc_load_q, pc_load_d;
  logic   instr_valid_q, instr_valid_d, halted_q, halted_d;
  logic   addr_live_q, addr_live_d;
  word_t  mem_addr_q, mem_addr_d, pc_load_val_q, pc_load_val_d, instr_q, instr_d;
  logic   go_req;

  logic   is_jmp, is_skip, is_halt;
  word_t  jmp_tgt;

  fetch_seq8_dec u_dec (
    .instr   (instr_q),
    .is_jmp  (is_jmp),
    .is_skip (is_skip),
    .is_halt (is_halt),
    .jmp_tgt (jmp_tgt)
  );

`ifdef FETCH_SEQ8_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    pc_oe_d       = pc_oe_q;
    pc_en_d       = 1'b0;
    pc_load_d     = 1'b0;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    addr_live_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    pc_load_val_d = pc_load_val_q;
    instr_d       = instr_q;
    go_req        = 1'b0;
`ifdef FETCH_SEQ8_TIMEOUT_EN
    tmo_cnt_d     = 8'd0;
    err_d         = err_q;
`endif
    unique case (state_q)
      IDLE: go_req = run;
      REQ: begin
        // The counter settles on the same edge that enters REQ, so the address
        // is passed through live for the first cycle and captured there.
        if (addr_live_q) mem_addr_d = pc_q;
        if (bus.mem_ack) begin
          state_d       = HOLD;
          instr_d       = bus.mem_rdata;
          instr_valid_d = 1'b1;
          mem_req_d     = 1'b0;
          pc_oe_d       = 1'b0;
        end
`ifdef FETCH_SEQ8_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = HALTED;
          mem_req_d = 1'b0;
          pc_oe_d   = 1'b0;
          err_d     = 1'b1;
          halted_d  = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      HOLD: if (bus.instr_ready) begin
        state_d       = ISSUE;
        instr_valid_d = 1'b0;
        pc_en_d       = !is_jmp && !is_halt;
        pc_load_d     = is_jmp;
        if (is_jmp) pc_load_val_d = jmp_tgt;
      end
      ISSUE: begin
        if (is_halt) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else if (is_skip) begin
          state_d = ISSUE2;
          pc_en_d = 1'b1;
        end else begin
          state_d = IDLE;
          go_req  = run;
        end
      end
      ISSUE2: begin
        state_d = IDLE;
        go_req  = run;
      end
      HALTED: if (!run) begin
        state_d  = IDLE;
        halted_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (go_req) begin
      state_d     = REQ;
      mem_req_d   = 1'b1;
      pc_oe_d     = 1'b1;
      addr_live_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      pc_oe_q       <= 1'b0;
      pc_en_q       <= 1'b0;
      pc_load_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      addr_live_q   <= 1'b0;
      mem_addr_q    <= 8'h00;
      pc_load_val_q <= 8'h00;
      instr_q       <= 8'h00;
`ifdef FETCH_SEQ8_TIMEOUT_EN
      tmo_cnt_q     <= 8'd0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      pc_oe_q       <= pc_oe_d;
      pc_en_q       <= pc_en_d;
      pc_load_q     <= pc_load_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      addr_live_q   <= addr_live_d;
      mem_addr_q    <= mem_addr_d;
      pc_load_val_q <= pc_load_val_d;
      instr_q       <= instr_d;
`ifdef FETCH_SEQ8_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      err_q         <= err_d;
`endif
    end
  end

  assign pc_en           = pc_en_q;
  assign pc_load         = pc_load_q;
  assign pc_load_val     = pc_load_val_q;
  assign pc_oe           = pc_oe_q;
  assign halted          = halted_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = addr_live_q ? pc_q : mem_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
`ifdef FETCH_SEQ8_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule
